// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: FFT config, data-in and data-out handshakes.
// master = sequencer side, slave = FFT core side.
interface fft_frame_sequencer_if;
  logic [7:0]  cfgTdata;
  logic        cfgTvalid;
  logic        cfgTready;
  logic [15:0] sTdata;
  logic        sTvalid;
  logic        sTready;
  logic        sTlast;
  logic        mTvalid;
  logic        mTlast;

  modport master (
    output cfgTdata, cfgTvalid,
    input  cfgTready,
    output sTdata, sTvalid, sTlast,
    input  sTready,
    input  mTvalid, mTlast
  );

  modport slave (
    input  cfgTdata, cfgTvalid,
    output cfgTready,
    input  sTdata, sTvalid, sTlast,
    output sTready,
    output mTvalid, mTlast
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: FFT reset/config, capture arm, frame load, unload.
// Option macro FFT_SEQ_FREERUN_EN: rearm automatically after each frame.
module fft_frame_sequencer #(
  parameter int unsigned NPTS_LOG2 = 10,
  parameter logic [7:0]  CFG_WORD  = 8'h00
) (
  input  logic                 ckaTime,
  input  logic                 aresetn,
  input  logic                 flgRestart,
  input  logic                 flgStartAcquisition,
  input  logic                 flgCaptureDone,
  output logic                 flgArmCapture,
  output logic [NPTS_LOG2-1:0] addrbTime,
  input  logic [7:0]           dinbTime,
  output logic                 fftResetn,
  fft_frame_sequencer_if.master axi,
  output logic [NPTS_LOG2-1:0] addrFreq,
  output logic                 busy,
  output logic                 flgFrameDone,
  output logic                 errFrame
);

  typedef enum logic [2:0] {
    RES0, RES1, CONFIG, IDLE,
    ARM, CAPTURE, LOAD, DRAIN
  } state_t;

  localparam logic [NPTS_LOG2-1:0] LAST = '1;

  state_t               state;
  logic                 cfg_valid;
  logic [NPTS_LOG2:0]   rd_cnt;
  logic [NPTS_LOG2-1:0] ld_cnt;
  logic                 inflight;
  logic [1:0]           fill;
  logic [7:0]           head;
  logic [7:0]           tail;
  logic [2:0]           occ;
  logic                 load;
  logic                 s_valid;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic                 last_acc;
  logic                 m_last;

  assign load     = state == LOAD;
  assign s_valid  = fill != 2'd0;
  assign pop      = s_valid && axi.sTready;
  assign push     = inflight;
  assign occ      = {1'b0, fill} + {2'b00, inflight}
                  - {2'b00, pop};
  assign issue    = load && !rd_cnt[NPTS_LOG2]
                  && occ < 3'd2;
  assign last_acc = pop && ld_cnt == LAST;
  assign m_last   = axi.mTvalid && axi.mTlast;

  assign addrbTime     = rd_cnt[NPTS_LOG2-1:0];
  assign axi.cfgTvalid = cfg_valid;
  assign axi.cfgTdata  = cfg_valid ? CFG_WORD : 8'h00;
  assign axi.sTvalid   = s_valid;
  assign axi.sTdata    = {8'h00, head};
  assign axi.sTlast    = s_valid && ld_cnt == LAST;

  // Frame FSM with registered control outputs
  always_ff @(posedge ckaTime or negedge aresetn) begin
    if (!aresetn) begin
      state         <= RES0;
      fftResetn     <= 1'b0;
      busy          <= 1'b1;
      cfg_valid     <= 1'b0;
      flgArmCapture <= 1'b0;
      flgFrameDone  <= 1'b0;
    end else begin
      flgArmCapture <= 1'b0;
      flgFrameDone  <= 1'b0;
      if (flgRestart) begin
        state     <= RES0;
        fftResetn <= 1'b0;
        busy      <= 1'b1;
        cfg_valid <= 1'b0;
      end else begin
        unique case (state)
          RES0: state <= RES1;
          RES1: begin
            state     <= CONFIG;
            fftResetn <= 1'b1;
            cfg_valid <= 1'b1;
          end
          CONFIG: if (axi.cfgTready) begin
            state     <= IDLE;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
          end
          IDLE: if (flgStartAcquisition) begin
            state         <= ARM;
            busy          <= 1'b1;
            flgArmCapture <= 1'b1;
          end
          ARM: state <= CAPTURE;
          CAPTURE: if (flgCaptureDone) state <= LOAD;
          LOAD: if (last_acc) begin
            state        <= DRAIN;
            flgFrameDone <= m_last;
          end
          DRAIN: begin
            if (flgFrameDone) begin
`ifdef FFT_SEQ_FREERUN_EN
              state         <= ARM;
              flgArmCapture <= 1'b1;
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              flgFrameDone <= m_last;
            end
          end
          default: state <= RES0;
        endcase
      end
    end
  end

  // Load path: read issue, BRAM latency tracking, 2-entry skid FIFO
  always_ff @(posedge ckaTime or negedge aresetn) begin
    if (!aresetn) begin
      rd_cnt   <= '0;
      ld_cnt   <= '0;
      inflight <= 1'b0;
      fill     <= 2'd0;
      head     <= 8'h00;
      tail     <= 8'h00;
    end else if (flgRestart || !load) begin
      rd_cnt   <= '0;
      ld_cnt   <= '0;
      inflight <= 1'b0;
      fill     <= 2'd0;
      head     <= 8'h00;
      tail     <= 8'h00;
    end else begin
      inflight <= issue;
      if (issue) rd_cnt <= rd_cnt + 1'b1;
      if (pop) ld_cnt <= ld_cnt + 1'b1;
      unique case ({push, pop})
        2'b10: begin
          if (fill == 2'd0) head <= dinbTime;
          else tail <= dinbTime;
          fill <= fill + 2'd1;
        end
        2'b01: begin
          head <= tail;
          fill <= fill - 2'd1;
        end
        2'b11: begin
          if (fill == 2'd1) begin
            head <= dinbTime;
          end else begin
            head <= tail;
            tail <= dinbTime;
          end
        end
        default: ;
      endcase
    end
  end

  // Unload index and sticky framing error
  always_ff @(posedge ckaTime or negedge aresetn) begin
    if (!aresetn) begin
      addrFreq <= '0;
      errFrame <= 1'b0;
    end else begin
      if (state == RES0 || state == RES1)
        addrFreq <= '0;
      else if (axi.mTvalid)
        addrFreq <= axi.mTlast ? '0 : addrFreq + 1'b1;
      if (state == RES0)
        errFrame <= 1'b0;
      else if (m_last && addrFreq != LAST)
        errFrame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed bench for fft_frame_sequencer.
// Build with FFT_SEQ_FREERUN_EN to exercise continuous frames.
module tb_fft_frame_sequencer;
  localparam int N = 1024;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       restart;
  logic       start;
  logic       cap_done;
  logic       arm;
  logic [9:0] addrb;
  logic [7:0] dinb;
  logic       fft_rst_n;
  logic [9:0] addr_freq;
  logic       busy;
  logic       frame_done;
  logic       err;

  int nchecks = 0;
  int nerrors = 0;

  fft_frame_sequencer_if bus();

  fft_frame_sequencer dut (
    .ckaTime             (clk),
    .aresetn             (aresetn),
    .flgRestart          (restart),
    .flgStartAcquisition (start),
    .flgCaptureDone      (cap_done),
    .flgArmCapture       (arm),
    .addrbTime           (addrb),
    .dinbTime            (dinb),
    .fftResetn           (fft_rst_n),
    .axi                 (bus),
    .addrFreq            (addr_freq),
    .busy                (busy),
    .flgFrameDone        (frame_done),
    .errFrame            (err)
  );

  always #5 clk = ~clk;

  // time buffer preloaded with addr[7:0], 1-cycle read latency
  always @(posedge clk) dinb <= addrb[7:0];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cfg_seq();
    int low;
    low = 0;
    while (fft_rst_n == 1'b0 && low < 10) begin
      low++;
      tick();
    end
    check("fft_reset_len", low, 2);
    check("cfg_valid", bus.cfgTvalid, 1);
    check("cfg_data", bus.cfgTdata, 8'h00);
    check("cfg_busy", busy, 1);
    repeat (4) begin
      tick();
      check("cfg_hold_v", bus.cfgTvalid, 1);
      check("cfg_hold_d", bus.cfgTdata, 8'h00);
    end
    bus.cfgTready = 1'b1;
    tick();
    bus.cfgTready = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_cfgv", bus.cfgTvalid, 0);
    check("idle_fftrst", fft_rst_n, 1);
    check("err_clear", err, 0);
  endtask

  task automatic reset_config();
    aresetn = 1'b0;
    repeat (3) tick();
    check("rst_fft", fft_rst_n, 0);
    check("rst_busy", busy, 1);
    check("rst_arm", arm, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_cfgv", bus.cfgTvalid, 0);
    check("rst_sv", bus.sTvalid, 0);
    check("rst_sd", bus.sTdata, 0);
    check("rst_sl", bus.sTlast, 0);
    check("rst_addrb", addrb, 0);
    check("rst_freq", addr_freq, 0);
    aresetn = 1'b1;
    cfg_seq();
  endtask

  // entered in the ARM cycle; stop_at >= 0 stops before that beat
  task automatic run_load(input bit rnd, input int stop_at);
    int beats;
    int cyc;
    bit stall;
    bit rdy;
    logic [15:0] pd;
    logic pl;
    beats = 0;
    cyc = 0;
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    check("arm_pulse", arm, 1);
    check("arm_busy", busy, 1);
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    check("arm_once", arm, 0);
    repeat (18) tick();
    check("capture_addrb", addrb, 0);
    check("capture_sv", bus.sTvalid, 0);
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    while (beats < N && cyc < 5000) begin
      if (stop_at >= 0 && beats == stop_at) break;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.sTready = rdy;
      if (cyc < 2) check("lat_idle", bus.sTvalid, 0);
      if (cyc == 2) check("lat_first", bus.sTvalid, 1);
      if (stall) begin
        check("stall_v", bus.sTvalid, 1);
        check("stall_d", bus.sTdata, pd);
        check("stall_l", bus.sTlast, pl);
      end
      if (bus.sTvalid) begin
        check("last", bus.sTlast, beats == N - 1);
        if (rdy) begin
          check("data", bus.sTdata, beats & 255);
          beats++;
        end
      end
      stall = bus.sTvalid && !rdy;
      pd = bus.sTdata;
      pl = bus.sTlast;
      tick();
      cyc++;
    end
    bus.sTready = 1'b0;
    check("beats", beats, stop_at < 0 ? N : stop_at);
    if (stop_at < 0) begin
      if (!rnd) check("rate", cyc, N + 2);
      check("drain_busy", busy, 1);
      check("drain_sv", bus.sTvalid, 0);
    end
  endtask

  task automatic unload(input int last_at, input bit exp_err);
    for (int i = 0; i <= last_at; i++) begin
      check("addr_freq", addr_freq, i);
      if (i == last_at) check("done_early", frame_done, 0);
      bus.mTvalid = 1'b1;
      bus.mTlast = (i == last_at);
      tick();
    end
    bus.mTvalid = 1'b0;
    bus.mTlast = 1'b0;
    check("done_pulse", frame_done, 1);
    check("freq_wrap", addr_freq, 0);
    check("err_frame", err, exp_err);
    tick();
    check("done_once", frame_done, 0);
`ifdef FFT_SEQ_FREERUN_EN
    check("rearm", arm, 1);
`else
    check("idle", busy, 0);
    check("no_rearm", arm, 0);
`endif
  endtask

  task automatic restart_seq();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_busy", busy, 1);
    check("rs_sv", bus.sTvalid, 0);
    check("rs_fft", fft_rst_n, 0);
    check("rs_cfgv", bus.cfgTvalid, 0);
    cfg_seq();
  endtask

  initial begin
    aresetn = 1'b1;
    restart = 1'b0;
    start = 1'b0;
    cap_done = 1'b0;
    bus.cfgTready = 1'b0;
    bus.sTready = 1'b0;
    bus.mTvalid = 1'b0;
    bus.mTlast = 1'b0;
    #2;
    reset_config();
`ifdef FFT_SEQ_FREERUN_EN
    start_pulse();
    for (int f = 0; f < 3; f++) begin
      run_load(f == 1, -1);
      unload(N - 1, 1'b0);
    end
`else
    start_pulse();
    run_load(1'b0, -1);
    unload(N - 1, 1'b0);
    start_pulse();
    run_load(1'b1, -1);
    unload(500, 1'b1);
    start_pulse();
    run_load(1'b1, 300);
    restart_seq();
    start_pulse();
    run_load(1'b0, -1);
    unload(N - 1, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
